multi_sine_reader: RTL and testbench



---
 rtl/sine_pkg.sv | 23 ++
 rtl/dffr.sv | 20 ++
 rtl/sine_fold.sv | 36 +++
 rtl/sine_rom.sv | 36 +++
 rtl/multi_sine_reader.sv | 183 ++++++++++++++++++
 tb/tb_multi_sine_reader.sv | 236 +++++++++++++++++++++++
 6 files changed

// File: rtl/sine_pkg.sv
// Shared definitions for the sine readers: default widths, sweep FSM states,
// quadrant codes and the largest quarter-wave ROM magnitude.
package sine_pkg;

   localparam int DEF_VOICES   = 3;
   localparam int DEF_STEP_W   = 20;
   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_SAMPLE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      FOLD = 2'd2
   } state_e;

   localparam logic [1:0] QUAD0 = 2'd0;
   localparam logic [1:0] QUAD1 = 2'd1;
   localparam logic [1:0] QUAD2 = 2'd2;
   localparam logic [1:0] QUAD3 = 2'd3;

   localparam logic [15:0] ROM_MAX = 16'h7FFF;

endpackage

// File: rtl/dffr.sv
// Enabled register with synchronous active-high clear; building block for
// the phase and step storage arrays.
module dffr #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/sine_fold.sv
// Combinational quadrant folding: mirrors the ROM address in odd quadrants
// and negates the magnitude in the lower half-wave.
module sine_fold
   import sine_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int SAMPLE_W = DEF_SAMPLE_W
) (
   input  logic [1:0]                 quad,
   input  logic [ADDR_W-1:0]          addr_in,
   input  logic [SAMPLE_W-1:0]        rom_data,
   output logic [ADDR_W-1:0]          rom_addr,
   output logic signed [SAMPLE_W-1:0] sample
);

   // ROM magnitudes never exceed 0x7FFF, so the negation cannot overflow
   function automatic logic signed [SAMPLE_W-1:0] negate(input logic [SAMPLE_W-1:0] m);
      return -$signed(m);
   endfunction

   always_comb begin
      rom_addr = addr_in;
      sample   = $signed(rom_data);
      case (quad)
         QUAD0: ;
         QUAD1: rom_addr = ~addr_in;
         QUAD2: sample = negate(rom_data);
         QUAD3: begin
            rom_addr = ~addr_in;
            sample   = negate(rom_data);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sine_rom.sv
// Quarter-wave sine magnitude ROM, one-cycle registered read. Contents are a
// parabolic approximation a*(2*AMAX-a), scaled so the table peaks near ROM_MAX.
module sine_rom
   import sine_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_SAMPLE_W
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   localparam int AMAX = (1 << ADDR_W) - 1;
   localparam int SH   = 2 * ADDR_W - 15;

   function automatic logic [DATA_W-1:0] rom_value(input logic [ADDR_W-1:0] a);
      logic [31:0] x;
      logic [31:0] p;
      x = 32'(a);
      p = (x * (32'(2 * AMAX) - x)) >> SH;
      if (p > 32'(ROM_MAX))
         p = 32'(ROM_MAX);
      return DATA_W'(p);
   endfunction

   logic [DATA_W-1:0] data_d;
   logic [DATA_W-1:0] data_q;

   always_comb data_d = rom_value(addr);

   always_ff @(posedge clk) data_q <= data_d;

   assign data = data_q;

endmodule

// File: rtl/multi_sine_reader.sv
// Time-multiplexed multi-voice sine reader sharing one quarter-wave ROM.
// Optional summed mix output enabled by defining MULTI_SINE_MIX_EN.
module multi_sine_reader
   import sine_pkg::*;
#(
   parameter int VOICES   = DEF_VOICES,
   parameter int STEP_W   = DEF_STEP_W,
   parameter int PHASE_W  = STEP_W + 2,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   localparam int VW      = (VOICES > 1) ? $clog2(VOICES) : 1,
   localparam int MIX_W   = SAMPLE_W + $clog2(VOICES)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [VOICES*STEP_W-1:0]    step_size,
   input  logic                        generate_next,
   output logic                        busy,
   output logic                        sample_ready,
   output logic [VW-1:0]               sample_voice,
   output logic signed [SAMPLE_W-1:0]  sample,
   output logic signed [MIX_W-1:0]     mix_sample,
   output logic                        mix_ready
);

   state_e                      state_q, state_d;
   logic [VW-1:0]               v_q, v_d;
   logic                        busy_q, busy_d;
   logic                        sample_ready_q, sample_ready_d;
   logic signed [SAMPLE_W-1:0]  sample_q, sample_d;
   logic [VW-1:0]               sample_voice_q, sample_voice_d;

   logic                             accept;
   logic                             fold_en;
   logic                             last_voice;
   logic [VOICES*STEP_W-1:0]         step_q;
   logic [VOICES-1:0][PHASE_W-1:0]   phase_q;
   logic [ADDR_W-1:0]                rom_addr;
   logic [SAMPLE_W-1:0]              rom_data;
   logic signed [SAMPLE_W-1:0]       fold_sample;

   assign accept     = (state_q == IDLE) && generate_next;
   assign fold_en    = (state_q == FOLD);
   assign last_voice = (v_q == VW'(VOICES - 1));

   dffr #(.W(VOICES*STEP_W)) u_step (
      .clk   (clk),
      .reset (reset),
      .en    (accept),
      .d     (step_size),
      .q     (step_q)
   );

   // Each voice's phase advances only in its own FOLD slot
   for (genvar g = 0; g < VOICES; g++) begin : g_voice
      logic [PHASE_W-1:0] phase_d;
      assign phase_d = phase_q[g] + PHASE_W'(step_q[g*STEP_W +: STEP_W]);
      dffr #(.W(PHASE_W)) u_phase (
         .clk   (clk),
         .reset (reset),
         .en    (fold_en && (v_q == VW'(g))),
         .d     (phase_d),
         .q     (phase_q[g])
      );
   end

   // The phase of voice v is stable across RD and FOLD, so one fold instance
   // both generates the address and folds the returned data
   sine_fold #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) u_fold (
      .quad     (phase_q[v_q][PHASE_W-1 -: 2]),
      .addr_in  (phase_q[v_q][STEP_W-1 -: ADDR_W]),
      .rom_data (rom_data),
      .rom_addr (rom_addr),
      .sample   (fold_sample)
   );

   sine_rom #(.ADDR_W(ADDR_W), .DATA_W(SAMPLE_W)) u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .data (rom_data)
   );

   always_comb begin
      state_d        = state_q;
      v_d            = v_q;
      busy_d         = busy_q;
      sample_ready_d = 1'b0;
      sample_d       = sample_q;
      sample_voice_d = sample_voice_q;
      case (state_q)
         IDLE: begin
            if (generate_next) begin
               state_d = RD;
               v_d     = '0;
               busy_d  = 1'b1;
            end
         end
         RD: state_d = FOLD;
         FOLD: begin
            sample_d       = fold_sample;
            sample_voice_d = v_q;
            sample_ready_d = 1'b1;
            if (last_voice) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d = RD;
               v_d     = v_q + VW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         v_q            <= '0;
         busy_q         <= 1'b0;
         sample_ready_q <= 1'b0;
         sample_q       <= '0;
         sample_voice_q <= '0;
      end else begin
         state_q        <= state_d;
         v_q            <= v_d;
         busy_q         <= busy_d;
         sample_ready_q <= sample_ready_d;
         sample_q       <= sample_d;
         sample_voice_q <= sample_voice_d;
      end
   end

   assign busy         = busy_q;
   assign sample_ready = sample_ready_q;
   assign sample       = sample_q;
   assign sample_voice = sample_voice_q;

`ifdef MULTI_SINE_MIX_EN
   logic signed [MIX_W-1:0] acc_q, acc_d;
   logic signed [MIX_W-1:0] mix_q, mix_d;
   logic                    mix_ready_q, mix_ready_d;
   logic signed [MIX_W-1:0] acc_sum;

   assign acc_sum = acc_q + MIX_W'(fold_sample);

   always_comb begin
      acc_d       = acc_q;
      mix_d       = mix_q;
      mix_ready_d = 1'b0;
      if (accept) begin
         acc_d = '0;
      end else if (fold_en) begin
         acc_d = acc_sum;
         if (last_voice) begin
            mix_d       = acc_sum;
            mix_ready_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         mix_q       <= '0;
         mix_ready_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         mix_q       <= mix_d;
         mix_ready_q <= mix_ready_d;
      end
   end

   assign mix_sample = mix_q;
   assign mix_ready  = mix_ready_q;
`else
   assign mix_sample = '0;
   assign mix_ready  = 1'b0;
`endif

endmodule

// File: tb/tb_multi_sine_reader.sv
// Scoreboard bench for multi_sine_reader (3 voices); checks mix when built
// with MULTI_SINE_MIX_EN, otherwise checks that the mix outputs stay 0.
module tb_multi_sine_reader;

   localparam int V  = 3;
   localparam int SW = 20;
   localparam int PW = 22;
   localparam int DW = 16;
   localparam int VW = 2;
   localparam int MW = 18;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   generate_next = 1'b0;
   logic [V*SW-1:0]        step_size = '0;
   logic                   busy;
   logic                   sample_ready;
   logic [VW-1:0]          sample_voice;
   logic signed [DW-1:0]   sample;
   logic signed [MW-1:0]   mix_sample;
   logic                   mix_ready;

   always #5 clk = ~clk;

   multi_sine_reader #(.VOICES(V), .STEP_W(SW)) dut (
      .clk           (clk),
      .reset         (reset),
      .step_size     (step_size),
      .generate_next (generate_next),
      .busy          (busy),
      .sample_ready  (sample_ready),
      .sample_voice  (sample_voice),
      .sample        (sample),
      .mix_sample    (mix_sample),
      .mix_ready     (mix_ready)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int rom_ref(input int a);
      int r;
      r = (a * (2046 - a)) / 32;
      return (r > 32767) ? 32767 : r;
   endfunction

   function automatic int ref_sample(input logic [PW-1:0] ph);
      int q;
      int a;
      q = int'(ph[PW-1:PW-2]);
      a = int'(ph[SW-1:SW-10]);
      if (q == 1 || q == 3) a = 1023 - a;
      return (q >= 2) ? -rom_ref(a) : rom_ref(a);
   endfunction

   typedef struct {
      int voice;
      int smp;
      int due;
   } exp_t;

   exp_t        eq[$];
   int          mq_val[$];
   int          mq_due[$];
   logic [PW-1:0] ph [V];
   int          busy_cnt = 0;
   int          rst_gen  = 0;
   int          msum;
   int          ms;
   bit          arm = 1'b0;

   // Reference model: decides accepts and queues expected strobes with due cycle
   always @(posedge clk) begin
      if (reset) begin
         arm = 1'b1;
         rst_gen++;
         busy_cnt = 0;
         eq.delete();
         mq_val.delete();
         mq_due.delete();
         for (int v = 0; v < V; v++) ph[v] = '0;
      end else if (busy_cnt == 0 && generate_next) begin
         msum = 0;
         for (int v = 0; v < V; v++) begin
            ms = ref_sample(ph[v]);
            msum += ms;
            eq.push_back('{voice: v, smp: ms, due: cyc + 3 + 2 * v});
            ph[v] = ph[v] + PW'(step_size[v*SW +: SW]);
         end
         mq_val.push_back(msum);
         mq_due.push_back(cyc + 2 * V + 1);
         busy_cnt = 2 * V;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
      cyc++;
   end

   int seen_gen = 0;
   int hold_s = 0;
   int hold_v = 0;
   int hold_m = 0;

   always @(negedge clk) begin
      if (arm) begin
         if (seen_gen != rst_gen) begin
            seen_gen = rst_gen;
            hold_s = 0;
            hold_v = 0;
            hold_m = 0;
         end
         chk("busy", busy, (busy_cnt > 0) ? 1 : 0);
         if (eq.size() > 0 && eq[0].due == cyc) begin
            chk("sample_ready", sample_ready, 1);
            hold_s = eq[0].smp;
            hold_v = eq[0].voice;
            void'(eq.pop_front());
         end else begin
            chk("no_strobe", sample_ready, 0);
         end
         chk("sample", sample, hold_s);
         chk("sample_voice", sample_voice, hold_v);
`ifdef MULTI_SINE_MIX_EN
         if (mq_due.size() > 0 && mq_due[0] == cyc) begin
            chk("mix_ready", mix_ready, 1);
            hold_m = mq_val[0];
            void'(mq_val.pop_front());
            void'(mq_due.pop_front());
         end else begin
            chk("no_mix_strobe", mix_ready, 0);
         end
         chk("mix_sample", mix_sample, hold_m);
`else
         chk("mix_tied", mix_sample, 0);
         chk("mix_ready_tied", mix_ready, 0);
`endif
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic req();
      generate_next = 1'b1;
      @(negedge clk);
      generate_next = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      wait_cyc(10);

      // voice 2 with step 0 must stay constant
      step_size = {20'h00000, 20'h00800, 20'h00400};
      repeat (2) begin
         req();
         wait_cyc(7);
      end

      // quadrant walk on voice 0 at the maximum request rate
      pulse_reset();
      step_size = {20'h12345, 20'h40000, 20'h80000};
      repeat (9) begin
         req();
         wait_cyc(6);
      end
      wait_cyc(2);

      // a second request while busy is dropped
      req();
      wait_cyc(2);
      req();
      wait_cyc(8);

      // request held high; steps change mid-sweep
      generate_next = 1'b1;
      repeat (30) begin
         step_size = 60'({$urandom(), $urandom()});
         @(negedge clk);
      end
      generate_next = 1'b0;
      wait_cyc(8);

      // reset in cycle 4 of a sweep aborts it; next sweep restarts at phase 0
      step_size = {20'h0ABCD, 20'h11111, 20'h7F000};
      req();
      wait_cyc(3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wait_cyc(10);
      req();
      wait_cyc(8);

      // every voice reaches address 1023 of quadrant 0, then crosses into quadrant 1
      pulse_reset();
      step_size = {3{20'hFFC00}};
      repeat (3) begin
         req();
         wait_cyc(7);
      end

      repeat (6) begin
         step_size = 60'({$urandom(), $urandom()});
         req();
         wait_cyc($urandom_range(6, 9));
      end

      for (int i = 0; i < 50 && eq.size() > 0; i++) @(negedge clk);
      chk("drain", eq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
